jtagkey_buf_v3: RTL and testbench

Parametrised target-side buffer controller for the Bus Blaster CPLD, third generation of the JTAGkey buffer logic. It keeps the FTDI-to-target JTAG data path combinational and adds clocked behaviour:
- open-drain nSRST/nTRST drivers with minimum-pulse stretching;
- a debounced target-present flag;
- an optional built-in loopback self-test sequencer that replaces the static test-mode wiring.

---
 rtl/jtagkey_pkg.sv | 38 +++
 rtl/jtag_rst_stretch.sv | 71 +++++++
 rtl/jtagkey_buf_v3.sv | 212 +++++++++++++++++++++
 tb/tb_jtagkey_buf_v3.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtagkey_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtagkey_pkg
// Purpose  : Shared state encodings, default parameters and a width helper
//            for the jtagkey_buf_v3 target buffer controller.
// Revision : 3.0
// ============================================================================
package jtagkey_pkg;

  localparam int c_def_n_out       = 4;
  localparam int c_def_n_in        = 3;
  localparam int c_def_rst_stretch = 16;
  localparam int c_def_deb_cycles  = 8;
  localparam int c_def_st_settle   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } rst_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } st_state_t;

  // Bits needed to hold values 0..value-1; returns at least 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_rst_stretch.sv
`default_nettype none
// ============================================================================
// Module   : jtag_rst_stretch
// Purpose  : Open-drain reset line driver guaranteeing a minimum pulse of
//            RST_STRETCH clocks for any request.
// Revision : 3.0
// ============================================================================
module jtag_rst_stretch
  import jtagkey_pkg::*;
#(
  parameter int RST_STRETCH = c_def_rst_stretch
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic drv
);

  localparam int                c_cnt_w = clog2(RST_STRETCH);
  localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(RST_STRETCH - 1);

  rst_state_t         r_state;
  rst_state_t         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               r_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= req;
    end
  end

  // The counter keeps running through ASSERT so a long request has already
  // satisfied the minimum width by the time it is removed.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_req) begin
          w_state_nxt = ASSERT;
          w_cnt_nxt   = c_load;
        end
      end
      ASSERT: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        if (!r_req) w_state_nxt = (r_cnt == '0) ? IDLE : HOLD;
      end
      HOLD: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        if (r_req)             w_state_nxt = ASSERT;
        else if (r_cnt == '0)  w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign drv = (r_state != IDLE);

endmodule
`default_nettype wire

// File: rtl/jtagkey_buf_v3.sv
`default_nettype none
// ============================================================================
// Module   : jtagkey_buf_v3
// Purpose  : Bus Blaster target buffer controller: combinational JTAG path,
//            stretched nSRST/nTRST drivers, debounced target-present flag and
//            a loopback self-test built only when JTAGKEY_SELFTEST_EN is set.
// Revision : 3.0
// ============================================================================
module jtagkey_buf_v3
  import jtagkey_pkg::*;
#(
  parameter int N_OUT       = c_def_n_out,
  parameter int N_IN        = c_def_n_in,
  parameter int RST_STRETCH = c_def_rst_stretch,
  parameter int DEB_CYCLES  = c_def_deb_cycles,
  parameter int ST_SETTLE   = c_def_st_settle
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         FT_JTAG_OE,
  input  logic [N_OUT-1:0]             FT_OUT,
  output logic [N_OUT-1:0]             TGT_OUT,
  output logic [N_OUT-1:0]             TGT_OUT_OE,
  input  logic [N_IN-1:0]              TGT_IN,
  output logic [N_IN-1:0]              FT_IN,
  input  logic                         FT_nSRST_OUT,
  input  logic                         FT_nSRST_OE,
  input  logic                         FT_nTRST_OUT,
  input  logic                         FT_nTRST_OE,
  input  logic                         nSRST_IN,
  output logic                         FT_nSRST_IN,
  output logic                         nSRST_DRV,
  output logic                         nTRST_DRV,
  input  logic                         TARGET_PRESENT,
  output logic                         FT_TARGET_PRESENT,
  input  logic                         ST_START,
  output logic                         ST_BUSY,
  output logic                         ST_PASS,
  output logic                         ST_FAIL,
  output logic [clog2(2*N_OUT)-1:0]    ST_FAIL_STEP
);

  localparam int                 c_deb_w    = clog2(DEB_CYCLES + 1);
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);

  logic w_srst_req;
  logic w_trst_req;

  assign FT_IN       = TGT_IN;
  assign FT_nSRST_IN = nSRST_IN;

  // A reset request is active only when both the value and enable are low.
  assign w_srst_req = ~(FT_nSRST_OUT | FT_nSRST_OE);
  assign w_trst_req = ~(FT_nTRST_OUT | FT_nTRST_OE);

  jtag_rst_stretch #(.RST_STRETCH(RST_STRETCH)) u_srst_stretch (
    .clk   (CLK),
    .rst_n (nRST),
    .req   (w_srst_req),
    .drv   (nSRST_DRV)
  );

  jtag_rst_stretch #(.RST_STRETCH(RST_STRETCH)) u_trst_stretch (
    .clk   (CLK),
    .rst_n (nRST),
    .req   (w_trst_req),
    .drv   (nTRST_DRV)
  );

  logic               r_tp_meta;
  logic               r_tp_sync;
  logic               r_tp_out;
  logic [c_deb_w-1:0] r_deb_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_tp_meta <= 1'b0;
      r_tp_sync <= 1'b0;
      r_tp_out  <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_tp_meta <= TARGET_PRESENT;
      r_tp_sync <= r_tp_meta;
      if (r_tp_sync == r_tp_out) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == c_deb_last) begin
        r_tp_out  <= r_tp_sync;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign FT_TARGET_PRESENT = r_tp_out;

`ifdef JTAGKEY_SELFTEST_EN
  localparam int                 c_st_w        = clog2(2 * N_OUT);
  localparam logic [c_st_w-1:0]  c_last_step   = c_st_w'(2 * N_OUT - 1);
  localparam logic [c_st_w-1:0]  c_n_out_s     = c_st_w'(N_OUT);
  localparam int                 c_set_w       = clog2(ST_SETTLE);
  localparam logic [c_set_w-1:0] c_settle_last = c_set_w'(ST_SETTLE - 1);
  localparam int                 c_n_cmp       = (N_OUT < N_IN) ? N_OUT : N_IN;
  localparam logic [N_OUT-1:0]   c_one         = N_OUT'(1);

  st_state_t          r_st_state;
  st_state_t          w_st_nxt;
  logic [c_st_w-1:0]  r_step;
  logic [c_st_w-1:0]  w_step_nxt;
  logic [c_set_w-1:0] r_settle;
  logic [c_set_w-1:0] w_settle_nxt;
  logic               r_pass;
  logic               w_pass_nxt;
  logic               r_fail;
  logic               w_fail_nxt;
  logic [c_st_w-1:0]  r_fail_step;
  logic [c_st_w-1:0]  w_fail_step_nxt;
  logic [N_OUT-1:0]   w_pattern;
  logic               w_busy;
  logic               w_mismatch;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_st_state  <= ST_IDLE;
      r_step      <= '0;
      r_settle    <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_step <= '0;
    end else begin
      r_st_state  <= w_st_nxt;
      r_step      <= w_step_nxt;
      r_settle    <= w_settle_nxt;
      r_pass      <= w_pass_nxt;
      r_fail      <= w_fail_nxt;
      r_fail_step <= w_fail_step_nxt;
    end
  end

  // First half of the run walks a one, second half walks a zero.
  always_comb begin
    w_pattern = '0;
    if (r_step < c_n_out_s) w_pattern = c_one << r_step;
    else                    w_pattern = ~(c_one << (r_step - c_n_out_s));
  end

  assign w_mismatch = |(w_pattern[c_n_cmp-1:0] ^ TGT_IN[c_n_cmp-1:0]);
  assign w_busy     = (r_st_state == ST_DRIVE) || (r_st_state == ST_CHECK);

  always_comb begin
    w_st_nxt        = r_st_state;
    w_step_nxt      = r_step;
    w_settle_nxt    = r_settle;
    w_pass_nxt      = r_pass;
    w_fail_nxt      = r_fail;
    w_fail_step_nxt = r_fail_step;
    case (r_st_state)
      ST_IDLE, ST_DONE: begin
        if (ST_START) begin
          w_st_nxt        = ST_DRIVE;
          w_step_nxt      = '0;
          w_settle_nxt    = '0;
          w_pass_nxt      = 1'b0;
          w_fail_nxt      = 1'b0;
          w_fail_step_nxt = '0;
        end
      end
      ST_DRIVE: begin
        if (r_settle == c_settle_last) begin
          w_st_nxt     = ST_CHECK;
          w_settle_nxt = '0;
        end else begin
          w_settle_nxt = r_settle + 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_mismatch) begin
          w_fail_nxt      = 1'b1;
          w_fail_step_nxt = r_step;
          w_st_nxt        = ST_DONE;
        end else if (r_step == c_last_step) begin
          w_pass_nxt = 1'b1;
          w_st_nxt   = ST_DONE;
        end else begin
          w_step_nxt = r_step + 1'b1;
          w_st_nxt   = ST_DRIVE;
        end
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  assign TGT_OUT      = w_busy ? w_pattern : FT_OUT;
  assign TGT_OUT_OE   = w_busy ? {N_OUT{1'b1}} : {N_OUT{~FT_JTAG_OE}};
  assign ST_BUSY      = w_busy;
  assign ST_PASS      = r_pass;
  assign ST_FAIL      = r_fail;
  assign ST_FAIL_STEP = r_fail_step;
`else
  logic w_unused_st_start;

  assign w_unused_st_start = ST_START;
  assign TGT_OUT           = FT_OUT;
  assign TGT_OUT_OE        = {N_OUT{~FT_JTAG_OE}};
  assign ST_BUSY           = 1'b0;
  assign ST_PASS           = 1'b0;
  assign ST_FAIL           = 1'b0;
  assign ST_FAIL_STEP      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jtagkey_buf_v3.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtagkey_buf_v3
// Purpose  : Scoreboard bench for jtagkey_buf_v3; self-test cases are built
//            only when JTAGKEY_SELFTEST_EN is defined.
// Revision : 3.0
// ============================================================================
module tb_jtagkey_buf_v3;

  localparam int K_TGT_OUT = 0;
  localparam int K_TGT_OE  = 1;
  localparam int K_FT_IN   = 2;
  localparam int K_NSRST_I = 3;
  localparam int K_SRST    = 4;
  localparam int K_TRST    = 5;
  localparam int K_PRES    = 6;
  localparam int K_BUSY    = 7;
  localparam int K_PASS    = 8;
  localparam int K_FAIL    = 9;
  localparam int K_FSTEP   = 10;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
  } sb_t;

  logic       CLK;
  logic       nRST;
  logic       FT_JTAG_OE;
  logic [3:0] FT_OUT;
  logic [3:0] TGT_OUT;
  logic [3:0] TGT_OUT_OE;
  logic [2:0] TGT_IN;
  logic [2:0] FT_IN;
  logic       FT_nSRST_OUT, FT_nSRST_OE, FT_nTRST_OUT, FT_nTRST_OE;
  logic       nSRST_IN, FT_nSRST_IN, nSRST_DRV, nTRST_DRV;
  logic       TARGET_PRESENT, FT_TARGET_PRESENT;
  logic       ST_START, ST_BUSY, ST_PASS, ST_FAIL;
  logic [2:0] ST_FAIL_STEP;

  logic       loop_en;
  logic [2:0] stuck_mask;
  logic [2:0] tgt_in_drv;
  int         cyc;
  int         n_checks;
  int         n_errors;
  sb_t        sb[$];

  assign TGT_IN = loop_en ? (TGT_OUT[2:0] & stuck_mask) : tgt_in_drv;

  jtagkey_buf_v3 #(
    .N_OUT(4), .N_IN(3), .RST_STRETCH(16), .DEB_CYCLES(8), .ST_SETTLE(4)
  ) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .FT_JTAG_OE        (FT_JTAG_OE),
    .FT_OUT            (FT_OUT),
    .TGT_OUT           (TGT_OUT),
    .TGT_OUT_OE        (TGT_OUT_OE),
    .TGT_IN            (TGT_IN),
    .FT_IN             (FT_IN),
    .FT_nSRST_OUT      (FT_nSRST_OUT),
    .FT_nSRST_OE       (FT_nSRST_OE),
    .FT_nTRST_OUT      (FT_nTRST_OUT),
    .FT_nTRST_OE       (FT_nTRST_OE),
    .nSRST_IN          (nSRST_IN),
    .FT_nSRST_IN       (FT_nSRST_IN),
    .nSRST_DRV         (nSRST_DRV),
    .nTRST_DRV         (nTRST_DRV),
    .TARGET_PRESENT    (TARGET_PRESENT),
    .FT_TARGET_PRESENT (FT_TARGET_PRESENT),
    .ST_START          (ST_START),
    .ST_BUSY           (ST_BUSY),
    .ST_PASS           (ST_PASS),
    .ST_FAIL           (ST_FAIL),
    .ST_FAIL_STEP      (ST_FAIL_STEP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int k);
    case (k)
      K_TGT_OUT: return 32'(TGT_OUT);
      K_TGT_OE:  return 32'(TGT_OUT_OE);
      K_FT_IN:   return 32'(FT_IN);
      K_NSRST_I: return 32'(FT_nSRST_IN);
      K_SRST:    return 32'(nSRST_DRV);
      K_TRST:    return 32'(nTRST_DRV);
      K_PRES:    return 32'(FT_TARGET_PRESENT);
      K_BUSY:    return 32'(ST_BUSY);
      K_PASS:    return 32'(ST_PASS);
      K_FAIL:    return 32'(ST_FAIL);
      K_FSTEP:   return 32'(ST_FAIL_STEP);
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_TGT_OUT: return "tgt_out";
      K_TGT_OE:  return "tgt_out_oe";
      K_FT_IN:   return "ft_in";
      K_NSRST_I: return "ft_nsrst_in";
      K_SRST:    return "nsrst_drv";
      K_TRST:    return "ntrst_drv";
      K_PRES:    return "ft_target_present";
      K_BUSY:    return "st_busy";
      K_PASS:    return "st_pass";
      K_FAIL:    return "st_fail";
      K_FSTEP:   return "st_fail_step";
      default:   return "unknown";
    endcase
  endfunction

  // Monitor: retire every expectation due in the current cycle.
  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [31:0] act;
        act = sample(sb[i].kind);
        n_checks++;
        if (act !== sb[i].exp || sb[i].cyc != cyc) begin
          n_errors++;
          $display("FAIL %s cyc=%0d due=%0d actual=%0h expected=%0h",
                   kname(sb[i].kind), cyc, sb[i].cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int kind, input int dly, input logic [31:0] e);
    sb.push_back('{cyc + dly, kind, e});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    nRST = 1'b0;
    FT_JTAG_OE = 1'b1;
    FT_OUT = 4'b0000;
    FT_nSRST_OUT = 1'b1; FT_nSRST_OE = 1'b1;
    FT_nTRST_OUT = 1'b1; FT_nTRST_OE = 1'b1;
    nSRST_IN = 1'b1;
    TARGET_PRESENT = 1'b0;
    ST_START = 1'b0;
    loop_en = 1'b0;
    stuck_mask = 3'b111;
    tgt_in_drv = 3'b000;

    exp_at(K_SRST, 1, 0);  exp_at(K_TRST, 1, 0);  exp_at(K_PRES, 1, 0);
    exp_at(K_BUSY, 1, 0);  exp_at(K_PASS, 1, 0);  exp_at(K_FAIL, 1, 0);
    exp_at(K_FSTEP, 1, 0);
    tick(3);
    nRST = 1'b1;
    tick(2);

    // Combinational data path
    FT_JTAG_OE = 1'b0; FT_OUT = 4'b1010; tgt_in_drv = 3'b101; nSRST_IN = 1'b0;
    exp_at(K_TGT_OUT, 0, 4'b1010); exp_at(K_TGT_OE, 0, 4'b1111);
    exp_at(K_FT_IN, 0, 3'b101);    exp_at(K_NSRST_I, 0, 0);
    tick(1);
    FT_JTAG_OE = 1'b1; FT_OUT = 4'b0101; tgt_in_drv = 3'b010; nSRST_IN = 1'b1;
    exp_at(K_TGT_OUT, 0, 4'b0101); exp_at(K_TGT_OE, 0, 4'b0000);
    exp_at(K_FT_IN, 0, 3'b010);    exp_at(K_NSRST_I, 0, 1);
    tick(1);

    // One-cycle SRST request: exactly 16 clocks of drive
    FT_nSRST_OUT = 1'b0; FT_nSRST_OE = 1'b0;
    exp_at(K_SRST, 1, 0);
    for (int d = 2; d <= 17; d++) exp_at(K_SRST, d, 1);
    exp_at(K_SRST, 18, 0);
    exp_at(K_TRST, 2, 0);
    tick(1);
    FT_nSRST_OUT = 1'b1; FT_nSRST_OE = 1'b1;
    tick(24);

    // 40-cycle SRST request: 40 clocks of drive, low 2 clocks after release
    FT_nSRST_OUT = 1'b0; FT_nSRST_OE = 1'b0;
    exp_at(K_SRST, 1, 0);
    for (int d = 2; d <= 41; d++) exp_at(K_SRST, d, 1);
    exp_at(K_SRST, 42, 0); exp_at(K_SRST, 43, 0);
    tick(40);
    FT_nSRST_OUT = 1'b1; FT_nSRST_OE = 1'b1;
    tick(5);

    // Value low but enable high is not a request
    FT_nSRST_OUT = 1'b0;
    for (int d = 2; d <= 4; d++) exp_at(K_SRST, d, 0);
    tick(5);
    FT_nSRST_OUT = 1'b1;

    // One-cycle TRST request
    FT_nTRST_OUT = 1'b0; FT_nTRST_OE = 1'b0;
    exp_at(K_TRST, 2, 1); exp_at(K_TRST, 17, 1); exp_at(K_TRST, 18, 0);
    exp_at(K_SRST, 2, 0);
    tick(1);
    FT_nTRST_OUT = 1'b1; FT_nTRST_OE = 1'b1;
    tick(20);

    // Target present toggling every 3 cycles never passes the debouncer
    for (int t = 0; t < 10; t++) begin
      TARGET_PRESENT = ~TARGET_PRESENT;
      for (int d = 0; d < 3; d++) exp_at(K_PRES, d, 0);
      tick(3);
    end
    TARGET_PRESENT = 1'b0;
    tick(5);
    TARGET_PRESENT = 1'b1;
    exp_at(K_PRES, 9, 0); exp_at(K_PRES, 10, 1); exp_at(K_PRES, 15, 1);
    tick(16);

`ifdef JTAGKEY_SELFTEST_EN
    // Passing loopback run, with a start pulse during the run ignored
    FT_JTAG_OE = 1'b1; FT_OUT = 4'b0110; loop_en = 1'b1; stuck_mask = 3'b111;
    ST_START = 1'b1;
    exp_at(K_BUSY, 0, 0);
    exp_at(K_BUSY, 1, 1);          exp_at(K_TGT_OUT, 1, 4'b0001);
    exp_at(K_TGT_OE, 1, 4'b1111);  exp_at(K_TGT_OUT, 21, 4'b1110);
    exp_at(K_BUSY, 40, 1);         exp_at(K_PASS, 40, 0);
    exp_at(K_BUSY, 41, 0);         exp_at(K_PASS, 41, 1);
    exp_at(K_FAIL, 41, 0);         exp_at(K_TGT_OUT, 41, 4'b0110);
    exp_at(K_TGT_OE, 41, 4'b0000); exp_at(K_PASS, 45, 1);
    tick(1);
    ST_START = 1'b0;
    tick(9);
    ST_START = 1'b1;
    tick(1);
    ST_START = 1'b0;
    tick(36);

    // TGT_IN[1] stuck low fails at step 1
    stuck_mask = 3'b101;
    ST_START = 1'b1;
    exp_at(K_PASS, 1, 0);
    exp_at(K_BUSY, 10, 1);  exp_at(K_FAIL, 10, 0);
    exp_at(K_BUSY, 11, 0);  exp_at(K_FAIL, 11, 1);
    exp_at(K_FSTEP, 11, 1); exp_at(K_PASS, 11, 0);
    exp_at(K_FAIL, 20, 1);
    tick(1);
    ST_START = 1'b0;
    tick(20);

    // Reset asserted at step 5 releases pads and clears status
    stuck_mask = 3'b111;
    ST_START = 1'b1;
    FT_nTRST_OUT = 1'b0; FT_nTRST_OE = 1'b0;
    exp_at(K_FAIL, 1, 0);
    exp_at(K_BUSY, 26, 1); exp_at(K_TRST, 26, 1); exp_at(K_TGT_OE, 26, 4'b1111);
    tick(1);
    ST_START = 1'b0;
    tick(26);
    nRST = 1'b0;
    exp_at(K_BUSY, 0, 0);  exp_at(K_PASS, 0, 0);   exp_at(K_FAIL, 0, 0);
    exp_at(K_FSTEP, 0, 0); exp_at(K_TRST, 0, 0);   exp_at(K_PRES, 0, 0);
    exp_at(K_TGT_OE, 0, 4'b0000); exp_at(K_TGT_OUT, 0, 4'b0110);
    FT_nTRST_OUT = 1'b1; FT_nTRST_OE = 1'b1;
    tick(2);
    nRST = 1'b1;
    tick(3);
`else
    // Without the sequencer the start pulse has no effect
    FT_JTAG_OE = 1'b0; FT_OUT = 4'b0011; loop_en = 1'b1;
    ST_START = 1'b1;
    exp_at(K_BUSY, 1, 0);          exp_at(K_PASS, 1, 0);
    exp_at(K_FAIL, 1, 0);          exp_at(K_FSTEP, 1, 0);
    exp_at(K_TGT_OUT, 1, 4'b0011); exp_at(K_TGT_OE, 1, 4'b1111);
    exp_at(K_FT_IN, 1, 3'b011);
    tick(1);
    ST_START = 1'b0;
    exp_at(K_BUSY, 5, 0);          exp_at(K_TGT_OUT, 5, 4'b0011);
    tick(8);
`endif

    for (int i = 0; i < 200 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
      n_checks += sb.size();
      n_errors += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
